// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC time-setting path: edit-state encoding,
// field widths and limits, and wrap-aware field arithmetic.
package rtc_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;

    localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
    localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_t;

    // Out-of-range live values are replaced by zero when captured.
    function automatic logic [HOUR_W-1:0] clamp_hour(input logic [HOUR_W-1:0] h);
        return (h > MAX_HOUR) ? 5'd0 : h;
    endfunction

    function automatic logic [MIN_W-1:0] clamp_min(input logic [MIN_W-1:0] m);
        return (m > MAX_MIN) ? 6'd0 : m;
    endfunction

    // Step one unit up or down with explicit wrap compares.
    function automatic logic [HOUR_W-1:0] step_hour(input logic [HOUR_W-1:0] h,
                                                    input logic up);
        if (up) begin
            return (h == MAX_HOUR) ? 5'd0 : h + 5'd1;
        end else begin
            return (h == 5'd0) ? MAX_HOUR : h - 5'd1;
        end
    endfunction

    function automatic logic [MIN_W-1:0] step_min(input logic [MIN_W-1:0] m,
                                                  input logic up);
        if (up) begin
            return (m == MAX_MIN) ? 6'd0 : m + 6'd1;
        end else begin
            return (m == 6'd0) ? MAX_MIN : m - 6'd1;
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchroniser, stability counter and a press pulse
// that is high in the cycle the debounced level is about to rise.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1_r;
    logic             sync2_r;
    logic             deb_r;
    logic [CNT_W-1:0] cnt_r;
    logic             settle_s;

    assign settle_s = (sync2_r != deb_r) && (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign press    = settle_s & sync2_r;

    // Synchronise the raw input and track how long it has differed from the debounced level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            deb_r   <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            if (sync2_r == deb_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (settle_s) begin
                deb_r <= sync2_r;
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Hour/minute edit controller: debounced mode/up/down buttons drive a
// RUN -> SET_HOUR -> SET_MIN editor that commits with a one-cycle load.
module time_set_ctrl
    import rtc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_CYCLES    = 25000000,
    parameter int TIMEOUT_CYCLES  = 1000000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_mode,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    output logic [HOUR_W-1:0] set_hour,
    output logic [MIN_W-1:0]  set_min,
    output logic              load,
    output logic              setting,
    output logic              blank_hour,
    output logic              blank_min
);

    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int IDLE_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic mode_press_s, up_press_s, down_press_s;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk(clk), .reset(reset), .btn(btn_mode), .press(mode_press_s));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .reset(reset), .btn(btn_up), .press(up_press_s));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk(clk), .reset(reset), .btn(btn_down), .press(down_press_s));

    state_t              state_r, state_s;
    logic [HOUR_W-1:0]   hour_r, hour_s;
    logic [MIN_W-1:0]    min_r, min_s;
    logic [IDLE_W-1:0]   idle_r, idle_s;
    logic [BLINK_W-1:0]  blink_r, blink_s;
    logic                phase_r, phase_s;
    logic                load_s;
    logic                any_press_s, step_s, timeout_s, entering_s, accepted_s;

    assign set_hour = hour_r;
    assign set_min  = min_r;

    // Exactly one of up/down, with mode taking priority, counts as a step.
    assign any_press_s = mode_press_s | up_press_s | down_press_s;
    assign step_s      = ~mode_press_s & (up_press_s ^ down_press_s);
    assign timeout_s   = (idle_r == IDLE_W'(TIMEOUT_CYCLES - 1)) & ~any_press_s;

    // Next-state, shadow-field, idle-timer and blink-phase computation.
    always_comb begin
        state_s = state_r;
        hour_s  = hour_r;
        min_s   = min_r;
        load_s  = 1'b0;
        case (state_r)
            RUN: begin
                if (mode_press_s) begin
                    state_s = SET_HOUR;
                    hour_s  = clamp_hour(cur_hour);
                    min_s   = clamp_min(cur_min);
                end else begin
                    state_s = RUN;
                end
            end
            SET_HOUR: begin
                if (mode_press_s) begin
                    state_s = SET_MIN;
                end else if (step_s) begin
                    hour_s = step_hour(hour_r, up_press_s);
                end else if (timeout_s) begin
                    state_s = RUN;
                end else begin
                    state_s = SET_HOUR;
                end
            end
            SET_MIN: begin
                if (mode_press_s) begin
                    state_s = RUN;
                    load_s  = 1'b1;
                end else if (step_s) begin
                    min_s = step_min(min_r, up_press_s);
                end else if (timeout_s) begin
                    state_s = RUN;
                end else begin
                    state_s = SET_MIN;
                end
            end
            default: begin
                state_s = RUN;
            end
        endcase

        entering_s = (state_s != state_r) && (state_s != RUN);
        accepted_s = (state_r != RUN) && step_s;

        if ((state_s == RUN) || entering_s || any_press_s) begin
            idle_s = {IDLE_W{1'b0}};
        end else begin
            idle_s = idle_r + IDLE_W'(1);
        end

        // Restart the blink on entry and on every step so the new value shows at once.
        if ((state_s == RUN) || entering_s || accepted_s) begin
            blink_s = {BLINK_W{1'b0}};
            phase_s = 1'b0;
        end else if (blink_r == BLINK_W'(BLINK_CYCLES - 1)) begin
            blink_s = {BLINK_W{1'b0}};
            phase_s = ~phase_r;
        end else begin
            blink_s = blink_r + BLINK_W'(1);
            phase_s = phase_r;
        end
    end

    // FSM state, shadow fields and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= RUN;
            hour_r     <= 5'd0;
            min_r      <= 6'd0;
            idle_r     <= {IDLE_W{1'b0}};
            blink_r    <= {BLINK_W{1'b0}};
            phase_r    <= 1'b0;
            load       <= 1'b0;
            setting    <= 1'b0;
            blank_hour <= 1'b0;
            blank_min  <= 1'b0;
        end else begin
            state_r    <= state_s;
            hour_r     <= hour_s;
            min_r      <= min_s;
            idle_r     <= idle_s;
            blink_r    <= blink_s;
            phase_r    <= phase_s;
            load       <= load_s;
            setting    <= (state_s != RUN);
            blank_hour <= (state_s == SET_HOUR) & phase_s;
            blank_min  <= (state_s == SET_MIN) & phase_s;
        end
    end

endmodule
